// File: rtl/motor_pkg.sv
// Shared definitions for the MCU command receiver and the PWM stage it feeds.
package motor_pkg;

  localparam logic [6:0]  DUTY_MAX   = 7'd100;
  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned CNT_W      = 5;

  typedef struct packed {
    logic       sign;
    logic [6:0] mag;
  } motor_cmd_t;

  typedef enum logic {
    S_IDLE,
    S_RECV
  } spi_state_t;

  // Limit a requested magnitude to the PWM period.
  function automatic logic [6:0] clamp_duty(input logic [6:0] mag);
    return (mag > DUTY_MAX) ? DUTY_MAX : mag;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser with a previous-value register for edge detection.
module sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic r_s1;
  logic r_s2;
  logic r_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1   <= RST_VAL;
      r_s2   <= RST_VAL;
      r_prev <= RST_VAL;
    end else begin
      r_s1   <= d;
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  assign level = r_s2;
  assign rise  = r_s2 & ~r_prev;
  assign fall  = ~r_s2 & r_prev;

endmodule

// File: rtl/motor_cmd_spi.sv
// SPI-slave command receiver: 16-bit frames -> per-motor sign/duty, with clamp
// and a watchdog that zeroes both duties when the MCU goes quiet.
module motor_cmd_spi
  import motor_pkg::*;
#(
  parameter logic [23:0] WDOG_CYCLES = 24'd4_800_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sck,
  input  logic       cs_n,
  input  logic       sdi,
  output logic       motor1_sign,
  output logic [6:0] motor1_upperlimit,
  output logic       motor2_sign,
  output logic [6:0] motor2_upperlimit,
  output logic       load,
  output logic       frame_err,
  output logic       wdog_trip
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  logic w_sck_lvl, w_sck_rise, w_sck_fall;
  logic w_cs_lvl, w_cs_rise_raw, w_cs_fall_raw;
  logic w_sdi, w_sdi_rise, w_sdi_fall;
  logic w_unused;

  sync_edge #(.RST_VAL(1'b0)) u_sck (
    .clk(clk), .reset(reset), .d(sck),
    .level(w_sck_lvl), .rise(w_sck_rise), .fall(w_sck_fall)
  );

  sync_edge #(.RST_VAL(1'b1)) u_cs (
    .clk(clk), .reset(reset), .d(cs_n),
    .level(w_cs_lvl), .rise(w_cs_rise_raw), .fall(w_cs_fall_raw)
  );

  sync_edge #(.RST_VAL(1'b0)) u_sdi (
    .clk(clk), .reset(reset), .d(sdi),
    .level(w_sdi), .rise(w_sdi_rise), .fall(w_sdi_fall)
  );

  assign w_unused = ^{w_sck_lvl, w_sck_fall, w_cs_lvl, w_sdi_rise, w_sdi_fall};

  spi_state_t          r_state;
  logic [FRAME_BITS-1:0] r_shift;
  logic [CNT_W-1:0]    r_cnt;
  logic [23:0]         r_wdog;
  logic [1:0]          r_arm;
  logic                r_m1_sign, r_m2_sign;
  logic [6:0]          r_m1_duty, r_m2_duty;
  logic                r_load, r_frame_err, r_trip;

  // Chip-select edges are ignored until the synchroniser and previous-value
  // flops hold real pin samples, so a frame already in progress at reset
  // release is not mistaken for a new one.
  logic w_arm;
  logic w_cs_rise, w_cs_fall;
  logic w_commit;
  motor_cmd_t w_m1, w_m2;

  assign w_arm     = (r_arm == 2'd3);
  assign w_cs_rise = w_cs_rise_raw & w_arm;
  assign w_cs_fall = w_cs_fall_raw & w_arm;
  assign w_commit  = (r_state == S_RECV) && w_cs_rise && (r_cnt == CNT_FULL);
  assign w_m1      = r_shift[15:8];
  assign w_m2      = r_shift[7:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_wdog      <= '0;
      r_arm       <= '0;
      r_m1_sign   <= 1'b0;
      r_m2_sign   <= 1'b0;
      r_m1_duty   <= '0;
      r_m2_duty   <= '0;
      r_load      <= 1'b0;
      r_frame_err <= 1'b0;
      r_trip      <= 1'b0;
    end else begin
      r_load      <= 1'b0;
      r_frame_err <= 1'b0;
      if (!w_arm) r_arm <= r_arm + 2'd1;

      case (r_state)
        S_IDLE: begin
          if (w_cs_fall) begin
            r_state <= S_RECV;
            r_shift <= '0;
            r_cnt   <= '0;
          end
        end
        S_RECV: begin
          if (w_cs_rise) begin
            r_state <= S_IDLE;
            if (r_cnt != CNT_FULL) r_frame_err <= 1'b1;
          end else if (w_sck_rise) begin
            r_shift <= {r_shift[FRAME_BITS-2:0], w_sdi};
            if (r_cnt != CNT_SAT) r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // A commit wins over a watchdog trip landing on the same cycle.
      if (w_commit) begin
        r_m1_sign <= w_m1.sign;
        r_m1_duty <= clamp_duty(w_m1.mag);
        r_m2_sign <= w_m2.sign;
        r_m2_duty <= clamp_duty(w_m2.mag);
        r_load    <= 1'b1;
        r_trip    <= 1'b0;
        r_wdog    <= '0;
      end else if (r_wdog != WDOG_CYCLES) begin
        r_wdog <= r_wdog + 24'd1;
        if ((r_wdog + 24'd1) == WDOG_CYCLES) begin
          r_m1_duty <= '0;
          r_m2_duty <= '0;
          r_trip    <= 1'b1;
          r_load    <= 1'b1;
        end
      end
    end
  end

  assign motor1_sign       = r_m1_sign;
  assign motor1_upperlimit = r_m1_duty;
  assign motor2_sign       = r_m2_sign;
  assign motor2_upperlimit = r_m2_duty;
  assign load              = r_load;
  assign frame_err         = r_frame_err;
  assign wdog_trip         = r_trip;

endmodule

// File: tb/tb_motor_cmd_spi.sv
// Directed plus randomised frames against a behavioural model of the receiver.
module tb_motor_cmd_spi;

  localparam logic [23:0] WDOG = 24'd1000;

  logic       clk = 1'b0;
  logic       reset, sck, cs_n, sdi;
  logic       motor1_sign, motor2_sign;
  logic [6:0] motor1_upperlimit, motor2_upperlimit;
  logic       load, frame_err, wdog_trip;

  always #5 clk = ~clk;

  motor_cmd_spi #(.WDOG_CYCLES(WDOG)) dut (
    .clk(clk), .reset(reset), .sck(sck), .cs_n(cs_n), .sdi(sdi),
    .motor1_sign(motor1_sign), .motor1_upperlimit(motor1_upperlimit),
    .motor2_sign(motor2_sign), .motor2_upperlimit(motor2_upperlimit),
    .load(load), .frame_err(frame_err), .wdog_trip(wdog_trip)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int load_cnt = 0, err_cnt = 0, both_cnt = 0, last_load_cyc = 0;

  // Reference state: what the outputs should currently show.
  logic       m1s, m2s, mtrip;
  logic [6:0] m1d, m2d;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (load) begin
      load_cnt++;
      last_load_cyc = cyc;
    end
    if (frame_err) err_cnt++;
    if (load && frame_err) both_cnt++;
  end

  function automatic logic [6:0] ref_duty(input logic [6:0] mag);
    return (int'(mag) > 100) ? 7'd100 : mag;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_m1s"},  32'(motor1_sign),       32'(m1s));
    check({tag, "_m1d"},  32'(motor1_upperlimit), 32'(m1d));
    check({tag, "_m2s"},  32'(motor2_sign),       32'(m2s));
    check({tag, "_m2d"},  32'(motor2_upperlimit), 32'(m2d));
    check({tag, "_trip"}, 32'(wdog_trip),         32'(mtrip));
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) tick(1);
  endtask

  task automatic model_commit(input logic [15:0] f);
    m1s   = f[15];
    m1d   = ref_duty(f[14:8]);
    m2s   = f[7];
    m2d   = ref_duty(f[6:0]);
    mtrip = 1'b0;
  endtask

  task automatic model_reset();
    m1s = 1'b0; m2s = 1'b0; m1d = '0; m2d = '0; mtrip = 1'b0;
  endtask

  task automatic spi_begin();
    cs_n = 1'b0;
    tick(5);
  endtask

  task automatic spi_bits(input logic [16:0] data, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sdi = data[i];
      tick(5);
      sck = 1'b1;
      tick(5);
      sck = 1'b0;
    end
    tick(4);
  endtask

  // Raise cs_n and expect exactly one load or frame_err on the 3rd clk edge.
  task automatic spi_end_check(input string tag, input bit commit);
    int l0, e0;
    l0 = load_cnt;
    e0 = err_cnt;
    cs_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      check({tag, "_load_t"}, 32'(load),      32'(commit && k == 3));
      check({tag, "_ferr_t"}, 32'(frame_err), 32'(!commit && k == 3));
    end
    check({tag, "_nload"}, 32'(load_cnt - l0), commit ? 32'd1 : 32'd0);
    check({tag, "_nerr"},  32'(err_cnt - e0),  commit ? 32'd0 : 32'd1);
    sdi = 1'b0;
  endtask

  task automatic send(input string tag, input logic [16:0] data, input int n);
    spi_begin();
    spi_bits(data, n);
    if (n == 16) model_commit(data[15:0]);
    spi_end_check(tag, n == 16);
    check_outputs(tag);
  endtask

  initial begin
    int c0, l0, e0, n;
    logic [16:0] d;
    logic [15:0] f;

    reset = 1'b1; sck = 1'b0; cs_n = 1'b1; sdi = 1'b0;
    model_reset();
    tick(4);
    reset = 1'b0;
    check_outputs("reset");
    check("reset_load", 32'(load), 32'd0);
    check("reset_ferr", 32'(frame_err), 32'd0);
    tick(4);

    send("valid", 17'h08A32, 16);
    send("clamp_hi", 17'h07FE5, 16);
    send("clamp_edge", 17'h06464, 16);
    send("short15", 17'h01234, 15);
    send("long17", 17'h1ABCD, 17);

    // Randomised: arbitrary-length frame followed by a valid one.
    for (int it = 0; it < 8; it++) begin
      n = 15 + int'($urandom_range(0, 2));
      d = 17'($urandom);
      send("rnd_a", d, n);
      d = 17'($urandom);
      send("rnd_b", d, 16);
    end

    // Watchdog trip after silence.
    send("wd_frame", 17'h08A32, 16);
    c0 = last_load_cyc;
    l0 = load_cnt;
    wait_cyc(c0 + 999);
    check("wd_pre_trip", 32'(wdog_trip), 32'd0);
    check("wd_pre_load", 32'(load), 32'd0);
    wait_cyc(c0 + 1000);
    m1d = '0; m2d = '0; mtrip = 1'b1;
    check("wd_load", 32'(load), 32'd1);
    check_outputs("wd_trip");
    wait_cyc(c0 + 1400);
    check("wd_one_load", 32'(load_cnt - l0), 32'd1);
    check_outputs("wd_hold");
    send("wd_clear", 17'($urandom) & 17'h0FFFF, 16);

    // Commit landing on the would-be trip cycle.
    c0 = last_load_cyc;
    f = 16'($urandom);
    spi_begin();
    spi_bits({1'b0, f}, 16);
    check("race_setup", 32'(cyc < c0 + 997), 32'd1);
    wait_cyc(c0 + 997);
    l0 = load_cnt;
    cs_n = 1'b1;
    model_commit(f);
    wait_cyc(c0 + 999);
    check("race_early", 32'(load), 32'd0);
    wait_cyc(c0 + 1000);
    check("race_load", 32'(load), 32'd1);
    check_outputs("race");
    wait_cyc(c0 + 1001);
    check("race_after", 32'(load), 32'd0);
    check("race_nload", 32'(load_cnt - l0), 32'd1);
    sdi = 1'b0;
    tick(6);

    // Reset in the middle of a frame.
    spi_begin();
    spi_bits(17'($urandom), 8);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    model_reset();
    check_outputs("rst_mid_rel");
    l0 = load_cnt;
    e0 = err_cnt;
    spi_bits(17'($urandom), 8);
    cs_n = 1'b1;
    tick(10);
    check("rst_mid_nload", 32'(load_cnt - l0), 32'd0);
    check("rst_mid_nerr", 32'(err_cnt - e0), 32'd0);
    check_outputs("rst_mid");

    check("no_overlap", 32'(both_cnt), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
